router_wrap_iack_arbiter: RTL
=============================

// Module: router_wrap_iack_arbiter
// PURPOSE
//  Packet-locking round-robin arbiter for the router_wrap slice. Shares one output channel among
//  NUM_IN input ports and generates each port's IACK (input acknowledge) handshake.
//  - A grant is held from head flit to tail flit, so packets never interleave.
//  - A starvation watchdog releases a stalled lock.
//  - Its IACK outputs feed the slice's ff_IACK_* capture flops.
// PARAMETERS
//  NUM_IN   4    number of requesting input ports (>=1)
//  TIMEOUT  16   idle cycles of the locked port before forced release; 0 disables the watchdog
//  CNT_W    5    watchdog counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk            in   1                  fabric clock; single clock domain
//  reset          in   1                  synchronous, active-high reset
//  in_valid       in   NUM_IN             per-port flit valid
//  in_tail        in   NUM_IN             per-port last-flit-of-packet marker, qualified by in_valid
//  out_ready      in   1                  downstream accepts a flit this cycle
//  in_iack        out  NUM_IN             per-port acknowledge; one-hot or zero
//  grant_valid    out  1                  a port is locked (state LOCKED)
//  grant_id       out  $clog2(NUM_IN)     locked port index (1 bit when NUM_IN=1)
//  out_valid      out  1                  flit transferred this cycle (|in_iack)
//  timeout_err    out  1                  sticky: a watchdog release occurred
// BEHAVIOUR
//  Reset (sync): state=IDLE, rr_ptr=0, grant_id=0, wd_cnt=0, timeout_err=0.
//   Hence grant_valid=0, in_iack=0, out_valid=0 on the cycle after reset.
//   Reset asserted mid-packet aborts the lock immediately; no IACK is issued in the reset cycle.
//  States: IDLE, LOCKED. All state is registered; in_iack/out_valid are combinational from it.
//  IDLE:
//   - If |in_valid, pick the first valid port scanning rr_ptr, rr_ptr+1, ... mod NUM_IN.
//   - Next cycle: LOCKED, grant_id=pick, wd_cnt=0.
//   - No IACK is issued in IDLE (1-cycle arbitration latency).
//  LOCKED:
//   - in_iack[i] = (i==grant_id) & in_valid[i] & out_ready.
//   - Transfer with in_tail[grant_id]=1: next state IDLE, rr_ptr=(grant_id+1) mod NUM_IN.
//     Single-flit packet => lock lasts exactly one cycle.
//   - in_valid[grant_id]=0: wd_cnt++. Any other cycle clears wd_cnt to 0.
//     out_ready=0 with valid high is a stall, not starvation; it clears wd_cnt.
//   - TIMEOUT!=0 and wd_cnt==TIMEOUT-1 while still starved: next state IDLE, timeout_err<=1,
//     rr_ptr=(grant_id+1) mod NUM_IN.
//   - Requests from non-granted ports are ignored; they are held, never dropped.
//  Tail/starvation in the same cycle is impossible: starvation implies in_valid=0.
//  Tail on a non-granted port has no effect.
//  Pointer wrap: grant_id=NUM_IN-1 releases to rr_ptr=0.
//  NUM_IN=1: grant_id is tied to 0; the same round-robin logic applies.
//  timeout_err clears only on reset.
//  Fairness: a continuously requesting port waits at most NUM_IN-1 packets.
// STRUCTURE
//  Package router_arb_pkg:
//   - arb_state_t {IDLE, LOCKED}
//   - function idx_w(n) returning max(1,$clog2(n))
//  Sub-module rr_pick (combinational):
//   - inputs req[NUM_IN], ptr; outputs any, idx
//   - rotate, priority-encode, un-rotate
//  Top: state/ptr/grant/watchdog registers and IACK decode.
// TESTING
//  1 Reset then idle: in_valid=0 for 10 cycles -> grant_valid=0, in_iack=0 throughout.
//  2 Contention: NUM_IN=4, all ports valid, single-flit tails, out_ready=1.
//    -> grants ports 0,1,2,3,0 with IACK every 2nd cycle.
//  3 Locking: port 2 sends 3-flit packet while port 0 valid; out_ready low on flit 2 for 2 cycles.
//    -> in_iack=4'b0100 on 3 transfer cycles only; port 0 granted after tail.
//  4 Watchdog: TIMEOUT=4; port 1 locked, drops valid after head.
//    -> release 4 cycles later, timeout_err=1, next grant starts at port 2.
//  5 Reset mid-packet: reset during flit 2 of a 4-flit packet.
//    -> next cycle IDLE, rr_ptr=0, timeout_err=0; re-grant starts from port 0.
//  6 Wrap: lock port 3 with tail, ports 0 and 3 valid -> next grant is port 0.

Source files
------------

// File: rtl/router_arb_pkg.sv
// Shared types and helpers for the router_wrap IACK arbiter.
package router_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Index width for n ports; a single port still needs one bit.
  function automatic int idx_w(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/router_wrap_iack_arbiter_rr_pick.sv
// Round-robin pick: first requester at or after ptr, wrapping mod NUM_IN.
module rr_pick #(
  parameter int NUM_IN = 4,
  parameter int IW     = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic              any,
  output logic [IW-1:0]     idx
);

  localparam logic [IW:0] NUM_S = (IW+1)'(NUM_IN);

  logic [2*NUM_IN-1:0] dbl;
  logic [NUM_IN-1:0]   rot;
  logic [IW-1:0]       off;
  logic [IW:0]         sum;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NUM_IN-1:0];
    off = '0;
    for (int k = NUM_IN-1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NUM_S) sum = sum - NUM_S;
    idx = sum[IW-1:0];
    any = |req;
  end

endmodule

// File: rtl/router_wrap_iack_arbiter.sv
// Packet-locking round-robin arbiter with per-port IACK and a starvation watchdog.
//
//  state  | meaning
//  IDLE   | no lock; arbitrating among valid ports from rr_ptr
//  LOCKED | grant_id owns the channel until its tail transfers or the watchdog fires
module router_wrap_iack_arbiter
  import router_arb_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IN-1:0]         in_valid,
  input  logic [NUM_IN-1:0]         in_tail,
  input  logic                      out_ready,
  output logic [NUM_IN-1:0]         in_iack,
  output logic                      grant_valid,
  output logic [idx_w(NUM_IN)-1:0]  grant_id,
  output logic                      out_valid,
  output logic                      timeout_err
);

  localparam int                IW      = idx_w(NUM_IN);
  localparam logic [IW-1:0]     LAST_ID = IW'(NUM_IN-1);
  localparam bit                WD_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0]  WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT-1 : 0);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    grant_id_q, grant_id_d;
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  logic             pick_any;
  logic [IW-1:0]    pick_idx;
  logic             gnt_req;
  logic             gnt_tail;
  logic             starved;
  logic             wd_fire;
  logic             xfer;
  logic [IW-1:0]    next_ptr;
  logic [NUM_IN-1:0] iack;

  rr_pick #(.NUM_IN(NUM_IN), .IW(IW)) u_pick (
    .req (in_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign gnt_req  = in_valid[grant_id_q];
  assign gnt_tail = in_tail[grant_id_q];
  assign starved  = (state_q == LOCKED) && !gnt_req;
  assign wd_fire  = WD_EN && starved && (wd_cnt_q == WD_LAST);
  assign next_ptr = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;

  // IACK decode; suppressed during reset so an aborted lock moves no flit.
  always_comb begin
    iack = '0;
    if (!reset && (state_q == LOCKED) && gnt_req && out_ready) iack[grant_id_q] = 1'b1;
  end

  assign xfer = |iack;

  // Next-state: lock on a pick, release on tail transfer or watchdog expiry.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = LOCKED;
          grant_id_d = pick_idx;
          wd_cnt_d   = '0;
        end
      end
      LOCKED: begin
        if ((xfer && gnt_tail) || wd_fire) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
          wd_cnt_d = '0;
          if (wd_fire) timeout_err_d = 1'b1;
        end else if (starved) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end else begin
          wd_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign in_iack     = iack;
  assign out_valid   = xfer;
  assign grant_valid = (state_q == LOCKED);
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

endmodule
